// File: rtl/parser_pkg.sv
// Shared constants for the parser front end: stream/RAM widths, VLAN ID
// bit offsets inside the first beat, the segment collector state type and a
// helper that pulls the VLAN ID out of a beat.
package parser_pkg;

  localparam int PKG_AXIS_DATA_WIDTH  = 512;
  localparam int PKG_AXIS_TUSER_WIDTH = 128;
  localparam int PKG_NUM_SEGS         = 2;
  localparam int PKG_PARSER_RAM_WIDTH = 160;
  localparam int PKG_VLANID_WIDTH     = 12;
  localparam int PKG_RAM_ADDR_WIDTH   = 5;

  // VLAN ID lives in the 802.1Q TCI: low nibble of byte 14 holds the upper
  // four ID bits, byte 15 holds the lower eight.
  localparam int VLAN_HI_NIB_OFS = 112;
  localparam int VLAN_LO_BYTE_OFS = 120;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_2ND = 2'd1,
    FLUSH    = 2'd2
  } seg_state_e;

  function automatic logic [PKG_VLANID_WIDTH-1:0] vlan_id_of(
    input logic [PKG_AXIS_DATA_WIDTH-1:0] beat
  );
    return {beat[VLAN_HI_NIB_OFS+3:VLAN_HI_NIB_OFS],
            beat[VLAN_LO_BYTE_OFS+7:VLAN_LO_BYTE_OFS]};
  endfunction

endpackage

// File: rtl/parser_seg_collector.sv
// Collects the first two beats and first-beat tuser of each packet, reads the
// parser RAM entry selected by the VLAN ID, and presents all of it to the
// parser as one aligned single-cycle pulse. Later beats are dropped.
module parser_seg_collector
  import parser_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = PKG_AXIS_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = PKG_AXIS_TUSER_WIDTH,
  parameter int C_NUM_SEGS         = PKG_NUM_SEGS,
  parameter int C_PARSER_RAM_WIDTH = PKG_PARSER_RAM_WIDTH,
  parameter int C_VLANID_WIDTH     = PKG_VLANID_WIDTH,
  parameter int C_RAM_ADDR_WIDTH   = PKG_RAM_ADDR_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                                    s_axis_tvalid,
  input  logic                                    s_axis_tlast,
  output logic                                    s_axis_tready,
  output logic                                    ram_rd_en,
  output logic [C_RAM_ADDR_WIDTH-1:0]             ram_rd_addr,
  input  logic [C_PARSER_RAM_WIDTH-1:0]           ram_rd_data,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_out,
  output logic                                    segs_out_valid,
  output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st_out,
  output logic [C_PARSER_RAM_WIDTH-1:0]           bram_out,
  output logic                                    bram_out_valid
);

  seg_state_e                     state_r, state_s;
  logic [C_AXIS_DATA_WIDTH-1:0]   seg0_r, seg1_r, seg1_src_s;
  logic [C_AXIS_TUSER_WIDTH-1:0]  tuser_buf_r;
  logic [C_PARSER_RAM_WIDTH-1:0]  bram_buf_r, bram_src_s;
  logic [C_VLANID_WIDTH-1:0]      vlan_id_s;
  logic                           emit_pending_r, emit_pending_s;
  logic                           seg1_done_r, seg1_done_s;
  logic                           ram_pend_r, bram_got_r;
  logic                           accept_s, first_acc_s, seg1_arrive_s;
  logic                           emit_s, tready_s;

  // Handshake decode, emission decision and next-state/flag computation.
  // A second beat arriving this cycle counts as seg1 present so a late
  // second beat is emitted one cycle after it is accepted.
  always_comb begin
    accept_s       = s_axis_tvalid & s_axis_tready;
    first_acc_s    = accept_s & (state_r == IDLE);
    seg1_arrive_s  = accept_s & (state_r == WAIT_2ND);
    seg1_src_s     = seg1_done_r ? seg1_r : s_axis_tdata;
    bram_src_s     = ram_pend_r ? ram_rd_data : bram_buf_r;
    vlan_id_s      = vlan_id_of(s_axis_tdata);
    emit_s         = emit_pending_r & (seg1_done_r | seg1_arrive_s)
                   & (bram_got_r | ram_pend_r);
    state_s        = state_r;
    emit_pending_s = emit_pending_r;
    seg1_done_s    = seg1_done_r;
    if (emit_s) begin
      emit_pending_s = 1'b0;
      seg1_done_s    = 1'b0;
    end else begin
      emit_pending_s = emit_pending_r;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          emit_pending_s = 1'b1;
          if (s_axis_tlast) begin
            seg1_done_s = 1'b1;
          end else begin
            state_s = WAIT_2ND;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_2ND: begin
        if (accept_s) begin
          seg1_done_s = ~emit_s;
          state_s     = s_axis_tlast ? IDLE : FLUSH;
        end else begin
          state_s = WAIT_2ND;
        end
      end
      FLUSH: begin
        if (accept_s && s_axis_tlast) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    tready_s = (state_s == IDLE) ? ~emit_pending_s : 1'b1;
  end

  // FSM state, capture buffers, RAM request/return tracking and the
  // registered output pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      emit_pending_r <= 1'b0;
      seg1_done_r    <= 1'b0;
      ram_pend_r     <= 1'b0;
      bram_got_r     <= 1'b0;
      seg0_r         <= '0;
      seg1_r         <= '0;
      tuser_buf_r    <= '0;
      bram_buf_r     <= '0;
      s_axis_tready  <= 1'b0;
      ram_rd_en      <= 1'b0;
      ram_rd_addr    <= '0;
      segs_out       <= '0;
      segs_out_valid <= 1'b0;
      tuser_1st_out  <= '0;
      bram_out       <= '0;
      bram_out_valid <= 1'b0;
    end else begin
      state_r        <= state_s;
      emit_pending_r <= emit_pending_s;
      seg1_done_r    <= seg1_done_s;
      s_axis_tready  <= tready_s;
      ram_rd_en      <= first_acc_s;
      ram_pend_r     <= ram_rd_en;
      if (first_acc_s) begin
        seg0_r      <= s_axis_tdata;
        tuser_buf_r <= s_axis_tuser;
        ram_rd_addr <= C_RAM_ADDR_WIDTH'(vlan_id_s >> 4);
        if (s_axis_tlast) begin
          seg1_r <= '0;
        end else begin
          seg1_r <= seg1_r;
        end
      end else if (seg1_arrive_s) begin
        seg1_r <= s_axis_tdata;
      end else begin
        seg1_r <= seg1_r;
      end
      if (emit_s) begin
        bram_got_r <= 1'b0;
      end else if (ram_pend_r) begin
        bram_buf_r <= ram_rd_data;
        bram_got_r <= 1'b1;
      end else begin
        bram_got_r <= bram_got_r;
      end
      segs_out_valid <= emit_s;
      bram_out_valid <= emit_s;
      if (emit_s) begin
        segs_out      <= {seg1_src_s, seg0_r};
        tuser_1st_out <= tuser_buf_r;
        bram_out      <= bram_src_s;
      end else begin
        segs_out      <= segs_out;
      end
    end
  end

endmodule

// File: tb/tb_parser_seg_collector.sv
// Directed bench for parser_seg_collector with a packet-level reference
// model and a per-cycle compare of every output.
module tb_parser_seg_collector;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [511:0]   s_axis_tdata = '0;
  logic [127:0]   s_axis_tuser = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic           s_axis_tready;
  logic           ram_rd_en;
  logic [4:0]     ram_rd_addr;
  logic [159:0]   ram_rd_data = '0;
  logic [1023:0]  segs_out;
  logic           segs_out_valid;
  logic [127:0]   tuser_1st_out;
  logic [159:0]   bram_out;
  logic           bram_out_valid;

  parser_seg_collector dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .segs_out(segs_out), .segs_out_valid(segs_out_valid),
    .tuser_1st_out(tuser_1st_out), .bram_out(bram_out),
    .bram_out_valid(bram_out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses[$];
  logic [159:0] ram_mem [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference address: VLAN ID assembled from the header bytes, divided by 16,
  // kept modulo the 32-entry RAM.
  function automatic logic [4:0] model_addr(input logic [511:0] d);
    int vid;
    vid = int'(d[115:112]) * 256 + int'(d[127:120]);
    return 5'((vid / 16) % 32);
  endfunction

  function automatic logic [511:0] mk(input logic [11:0] vlan, input logic [7:0] tag);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    d[127:120] = vlan[7:0];
    d[115:112] = vlan[11:8];
    d[7:0] = tag;
    return d;
  endfunction

  // RAM model: one-cycle read latency, junk on the bus when not read.
  logic       re_q = 1'b0;
  logic [4:0] ra_q = '0;
  always @(negedge clk) begin
    re_q = ram_rd_en;
    ra_q = ram_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    ram_rd_data = (re_q === 1'b1) ? ram_mem[ra_q] : {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  // Packet-level model and per-cycle compare.
  bit           rst_prev = 1'b1;
  bit           open_pkt = 1'b0;
  bit           pend = 1'b0;
  bit           tr_exp;
  int           nbeats = 0;
  int           pe_cyc = 0;
  int           t_first = 0;
  int           rd_cyc = -10;
  logic [511:0] m_seg0 = '0, m_seg1 = '0;
  logic [127:0] m_tuser = '0;
  logic [4:0]   m_addr = '0;
  logic [1023:0] l_segs = '0;
  logic [127:0]  l_tuser = '0;
  logic [159:0]  l_bram = '0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_prev) begin
        open_pkt = 1'b0; pend = 1'b0; rd_cyc = -10;
        l_segs = '0; l_tuser = '0; l_bram = '0; m_addr = '0;
        tr_exp = 1'b0;
      end else begin
        tr_exp = open_pkt ? 1'b1 : ((pend && cyc < pe_cyc) ? 1'b0 : 1'b1);
      end
      chk("tready", 512'(s_axis_tready), 512'(tr_exp));
      chk("ram_rd_en", 512'(ram_rd_en), 512'(rd_cyc == cyc));
      chk("ram_rd_addr", 512'(ram_rd_addr), 512'(m_addr));
      if (!rst_prev && pend && cyc == pe_cyc) begin
        l_segs = {m_seg1, m_seg0};
        l_tuser = m_tuser;
        l_bram = ram_mem[m_addr];
        pend = 1'b0;
        chk("segs_valid", 512'(segs_out_valid), 512'(1));
      end else begin
        chk("segs_valid", 512'(segs_out_valid), 512'(0));
      end
      chk("bram_valid", 512'(bram_out_valid), 512'(segs_out_valid === 1'b1 ? 1 : 0));
      chk("segs_lo", segs_out[511:0], l_segs[511:0]);
      chk("segs_hi", segs_out[1023:512], l_segs[1023:512]);
      chk("tuser_1st", 512'(tuser_1st_out), 512'(l_tuser));
      chk("bram_out", 512'(bram_out), 512'(l_bram));
      if (segs_out_valid === 1'b1) pulses.push_back(cyc);
      if (!reset && s_axis_tvalid && tr_exp) begin
        if (!open_pkt) begin
          t_first = cyc;
          m_seg0 = s_axis_tdata;
          m_tuser = s_axis_tuser;
          m_addr = model_addr(s_axis_tdata);
          rd_cyc = cyc + 1;
          pend = 1'b1;
          if (s_axis_tlast) begin
            m_seg1 = '0;
            pe_cyc = cyc + 3;
          end else begin
            open_pkt = 1'b1;
            nbeats = 1;
            pe_cyc = 1 << 30;
          end
        end else begin
          nbeats++;
          if (nbeats == 2) begin
            m_seg1 = s_axis_tdata;
            pe_cyc = (t_first + 3 > cyc + 1) ? t_first + 3 : cyc + 1;
          end
          if (s_axis_tlast) open_pkt = 1'b0;
        end
      end
    end
    rst_prev = reset;
  end

  task automatic beat(input logic [511:0] d, input logic [127:0] u, input bit last, output int acc_cyc);
    bit acc;
    int n;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    acc = 1'b0; n = 0; acc_cyc = -1;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_tready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin
        total++; bad++;
        $display("FAIL beat_timeout act=no_accept exp=accept");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t, s, tl, tn, p0;
    for (int i = 0; i < 32; i++) ram_mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ram_mem[5'h12] = {20{8'hA5}};
    // Pin the model's address rule with hand-derived values.
    chk("model_addr_123", 512'(model_addr(mk(12'h123, 8'h00))), 512'(5'h12));
    chk("model_addr_010", 512'(model_addr(mk(12'h010, 8'h00))), 512'(5'h01));
    chk("model_addr_020", 512'(model_addr(mk(12'h020, 8'h00))), 512'(5'h02));
    chk("model_addr_fff", 512'(model_addr(mk(12'hFFF, 8'h00))), 512'(5'h1F));
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    idle(3);

    // 1: two-beat packet, VLAN 0x123
    p0 = pulses.size();
    beat(mk(12'h123, 8'h11), 128'hAAAA_0001, 1'b0, t);
    beat(mk(12'h123, 8'h12), 128'h0, 1'b1, s);
    idle(6);
    chk("t1_pulses", 512'(pulses.size() - p0), 512'(1));
    if (pulses.size() > p0) chk("t1_latency", 512'(pulses[p0] - t), 512'(3));
    chk("t1_bram_a5", 512'(bram_out), 512'({20{8'hA5}}));

    // 2: single-beat packet
    p0 = pulses.size();
    beat(mk(12'h045, 8'h21), 128'hBBBB_0002, 1'b1, t);
    idle(6);
    if (pulses.size() > p0) chk("t2_latency", 512'(pulses[p0] - t), 512'(3));
    chk("t2_seg1_zero", segs_out[1023:512], 512'(0));

    // 3: five-beat packet followed back-to-back by a one-beat packet
    p0 = pulses.size();
    beat(mk(12'h3A7, 8'h31), 128'hCCCC_0003, 1'b0, t);
    for (int i = 0; i < 3; i++) beat(mk(12'h000, 8'(8'h32 + i)), 128'h0, 1'b0, s);
    beat(mk(12'h000, 8'h36), 128'h0, 1'b1, tl);
    beat(mk(12'h0F0, 8'h37), 128'hCCCC_0004, 1'b1, tn);
    idle(6);
    chk("t3_next_first", 512'(tn - tl), 512'(1));
    chk("t3_pulses", 512'(pulses.size() - p0), 512'(2));
    if (pulses.size() > p0) chk("t3_latency", 512'(pulses[p0] - t), 512'(3));

    // 4: second beat six cycles after the first
    p0 = pulses.size();
    beat(mk(12'h123, 8'h41), 128'hDDDD_0005, 1'b0, t);
    idle(5);
    beat(mk(12'h555, 8'h42), 128'h0, 1'b1, s);
    idle(8);
    chk("t4_gap", 512'(s - t), 512'(6));
    chk("t4_pulses", 512'(pulses.size() - p0), 512'(1));
    if (pulses.size() > p0) chk("t4_latency", 512'(pulses[p0] - t), 512'(7));

    // 5: two consecutive single-beat packets, VLAN 0x010 then 0x020
    p0 = pulses.size();
    beat(mk(12'h010, 8'h51), 128'hEEEE_0006, 1'b1, t);
    beat(mk(12'h020, 8'h52), 128'hEEEE_0007, 1'b1, s);
    idle(6);
    chk("t5_spacing", 512'(s - t), 512'(3));
    chk("t5_pulses", 512'(pulses.size() - p0), 512'(2));
    if (pulses.size() > p0 + 1) chk("t5_pulse_gap", 512'(pulses[p0 + 1] - pulses[p0]), 512'(3));

    // 6: reset while waiting for the second beat
    p0 = pulses.size();
    beat(mk(12'h123, 8'h61), 128'hFFFF_0008, 1'b0, t);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(5);
    chk("t6_no_pulse", 512'(pulses.size() - p0), 512'(0));
    beat(mk(12'h020, 8'h62), 128'hFFFF_0009, 1'b1, t);
    idle(6);
    chk("t6_pulses", 512'(pulses.size() - p0), 512'(1));
    if (pulses.size() > p0) chk("t6_latency", 512'(pulses[p0] - t), 512'(3));

    chk("total_pulses", 512'(pulses.size()), 512'(8));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parser_seg_collector.md
Name: parser_seg_collector

Overview:
- Sits directly upstream of parser_do_parsing_top, fed by the packet-in AXI4-Stream.
- Captures the first C_NUM_SEGS (=2) beats of each packet plus the first-beat tuser. Issues a parser-RAM read indexed by the packet's VLAN ID.
- Presents segs / tuser_1st / RAM entry to the parser as one aligned single-cycle pulse. Drops remaining beats of the packet.

Parameters:
- C_AXIS_DATA_WIDTH, 512: beat width.
- C_AXIS_TUSER_WIDTH, 128: tuser width.
- C_NUM_SEGS, 2: beats captured per packet. Fixed at 2 in this revision.
- C_PARSER_RAM_WIDTH, 160: parser RAM entry width.
- C_VLANID_WIDTH, 12: VLAN ID width.
- C_RAM_ADDR_WIDTH, 5: parser RAM address width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  packet beat.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  sideband; meaningful on first beat only.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  beat accept.
- ram_rd_en  out  1  parser RAM read strobe.
- ram_rd_addr  out  C_RAM_ADDR_WIDTH  parser RAM address.
- ram_rd_data  in  C_PARSER_RAM_WIDTH  RAM data, valid exactly 1 cycle after ram_rd_en.
- segs_out  out  C_NUM_SEGS*C_AXIS_DATA_WIDTH  beat0 in [511:0], beat1 in [1023:512].
- segs_out_valid  out  1  one-cycle pulse per packet.
- tuser_1st_out  out  C_AXIS_TUSER_WIDTH  first-beat tuser.
- bram_out  out  C_PARSER_RAM_WIDTH  parser RAM entry.
- bram_out_valid  out  1  identical to segs_out_valid.

Behaviour:
- Reset: every output register is 0, including s_axis_tready, ram_rd_en, ram_rd_addr, segs_out, segs_out_valid, tuser_1st_out, bram_out and bram_out_valid.
  - The FSM goes to IDLE and the emit_pending, ram_pend and bram_got flags clear.
  - A partial packet caught by reset is discarded; no emission follows for it.
  - Beats of that packet arriving after reset deasserts are treated as a new packet (upstream must not reset mid-packet).
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready.
- FSM states: IDLE, WAIT_2ND, FLUSH.
  - IDLE: tready = ~emit_pending. On accept:
    - Latch beat0 into seg0 and tuser into tuser_buf.
    - Register ram_rd_en=1 (one-cycle pulse) and the read address.
    - Set emit_pending.
    - If tlast: seg1 <= 0, set seg1_done, stay IDLE. Otherwise go to WAIT_2ND.
  - WAIT_2ND: tready=1. On accept: seg1 <= tdata, set seg1_done. If tlast go to IDLE, else go to FLUSH.
  - FLUSH: tready=1. Beats are accepted and discarded. On accepted tlast, go to IDLE.
- VLAN extraction (first beat): vlan_id = {tdata[115:112], tdata[127:120]}. ram_rd_addr = vlan_id[C_RAM_ADDR_WIDTH+3:4].
- RAM return:
  - ram_pend is ram_rd_en delayed 1 cycle; ram_rd_data is valid in the cycle ram_pend=1.
  - If no emission occurs that cycle, capture ram_rd_data into bram_buf and set bram_got.
- Emission:
  - Condition: emit_pending & seg1_done & (bram_got | ram_pend).
  - Registered outputs load seg0/seg1, tuser_buf, and bram source (ram_rd_data if ram_pend, else bram_buf).
  - On emission, emit_pending, seg1_done and bram_got clear.
- Latency: first beat accepted in cycle T, second beat (or single-beat tlast) in S. Then segs_out_valid=1 in cycle max(T+3, S+1).
- Output data holds its value after the valid pulse until the next emission.
- Throughput: a new first beat is accepted no earlier than the cycle after its predecessor's emission is registered, so the minimum packet spacing is 3 cycles.
- Data outputs change only on emission.
- A 2-beat packet ending in WAIT_2ND with tlast returns to IDLE; emission may still be pending, in which case tready stays 0 until it completes.

Decomposition:
- Shared package parser_pkg: width constants and the VLAN-ID bit offsets (112/120), shared with parser_do_parsing.
- No sub-module. The FSM and emit logic live in one module.

Test Plan:
1. 2-beat packet, VLAN ID 0x123, first beat T, second beat T+1, RAM returns 0xA5.. → ram_rd_en at T+1 with addr 0x12; segs_out_valid=bram_out_valid=1 only at T+3 with beat0/beat1 and 0xA5.. entry.
2. 1-beat packet (tlast on first beat) → segs_out[1023:512]=0; valid at T+3; tready=0 in T+1..T+2, 1 at T+3.
3. 5-beat packet, back-to-back → beats 3–5 accepted and dropped with tready=1; single emission at T+3; next packet's first beat accepted the cycle after tlast.
4. Second beat delayed to T+6 → RAM data held in bram_buf; valid at T+7 with correct entry; no earlier pulse.
5. Two consecutive 1-beat packets (VLAN IDs 0x010, 0x020) → addrs 0x01 then 0x02; two pulses 3 cycles apart with matching tuser and RAM data.
6. reset asserted in WAIT_2ND for 2 cycles → all outputs 0, no emission; next packet processed normally with latency T+3.
